// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: forwards low addresses to dmem and serves a
// small MMIO block (status, tx FIFO, cycle counter, scratch) at the top.
module dmem_mmio_responder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [11:0] MMIO_BASE  = 12'hF00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_wren,
    input  logic [31:0] mem_q,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   fifo_q [FIFO_DEPTH];
    logic [31:0]   fifo_d [FIFO_DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cycle_q, cycle_d;
    logic [31:0]   scratch_q, scratch_d;
    logic          sel_q, sel_d;
    logic [31:0]   rdata_q, rdata_d;

    logic        is_mmio;
    logic [11:0] off;
    logic        sel_status, sel_tx, sel_cycle, sel_scratch;
    logic        empty, full, push, pop, do_push;
    logic [31:0] status;

    assign is_mmio     = address >= MMIO_BASE;
    assign off         = address - MMIO_BASE;
    assign sel_status  = is_mmio && (off == 12'd0);
    assign sel_tx      = is_mmio && (off == 12'd1);
    assign sel_cycle   = is_mmio && (off == 12'd2);
    assign sel_scratch = is_mmio && (off == 12'd3);

    assign mem_address = address;
    assign mem_data    = data;
    assign mem_wren    = wren && !is_mmio;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(FIFO_DEPTH));
    assign out_valid = !empty;
    assign out_data  = fifo_q[head_q];
    assign pop       = out_valid && out_ready;
    assign push      = wren && sel_tx;
    // A pop frees the head slot this edge, so a full FIFO still accepts.
    assign do_push   = push && (!full || pop);

    assign status = {23'd0, ovf_q, 6'(count_q), full, empty};

    assign q = sel_q ? rdata_q : mem_q;

    always_comb begin
        fifo_d    = fifo_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        cycle_d   = cycle_q + 32'd1;
        scratch_d = scratch_q;
        sel_d     = is_mmio;
        rdata_d   = '0;

        if (do_push) begin
            fifo_d[tail_q] = data;
            tail_d         = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (do_push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && pop) begin
            count_d = count_q - 1'b1;
        end

        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (wren && sel_status) begin
            ovf_d = 1'b0;
        end

        if (wren && sel_cycle) begin
            cycle_d = data;
        end
        if (wren && sel_scratch) begin
            scratch_d = data;
        end

        unique case (1'b1)
            sel_status:  rdata_d = status;
            sel_cycle:   rdata_d = cycle_q;
            sel_scratch: rdata_d = scratch_q;
            default:     rdata_d = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            cycle_q   <= '0;
            scratch_q <= '0;
            sel_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            fifo_q    <= fifo_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            cycle_q   <= cycle_d;
            scratch_q <= scratch_d;
            sel_q     <= sel_d;
            rdata_q   <= rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder with a behavioural dmem syncram.
module tb_dmem_mmio_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] address = '0;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic [31:0] q;
    logic [11:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    int ecnt     = 0;

    logic [31:0] dmem [4096];

    dmem_mmio_responder dut (
        .clock       (clock),
        .reset       (reset),
        .address     (address),
        .data        (data),
        .wren        (wren),
        .q           (q),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (mem_wren) dmem[mem_address] <= mem_data;
        mem_q <= dmem[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        ecnt++;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        ecnt  = 0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        address = a;
        data    = d;
        wren    = 1'b1;
        tick();
        wren    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] exp);
        address = a;
        wren    = 1'b0;
        tick();
        check(tag, q, exp);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) dmem[i] = '0;
        address = 12'h010;
        do_reset();

        // 1: idle after reset
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        rd("rst_status", 12'hF00, 32'h0000_0001);
        address = 12'hF02;
        tick();
        check("cycle_a", q, ecnt - 1);
        tick();
        check("cycle_b", q, ecnt - 1);
        tick();
        check("cycle_c", q, ecnt - 1);

        // 2: pass-through to dmem
        address = 12'h010;
        data    = 32'h0000_0123;
        wren    = 1'b1;
        #1;
        check("pt_wren", {31'd0, mem_wren}, 32'd1);
        check("pt_addr", {20'd0, mem_address}, 32'h010);
        check("pt_data", mem_data, 32'h0000_0123);
        tick();
        wren = 1'b0;
        rd("pt_read", 12'h010, 32'h0000_0123);

        // 3: overflow then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            address = 12'hF01;
            data    = 32'hA0 + i;
            wren    = 1'b1;
            #1;
            check("tx_wren", {31'd0, mem_wren}, 32'd0);
            tick();
        end
        wren = 1'b0;
        rd("ovf_status", 12'hF00, 32'h0000_0112);
        check("head_a0", out_data, 32'hA0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_v", {31'd0, out_valid}, 32'd1);
            check("drain_d", out_data, 32'hA0 + i);
            tick();
        end
        check("drain_end", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        wr(12'hF00, 32'h0);
        rd("ovf_clr", 12'hF00, 32'h0000_0001);

        // 4: push and pop together while full
        for (int i = 0; i < 4; i++) wr(12'hF01, 32'hC0 + i);
        out_ready = 1'b1;
        wr(12'hF01, 32'hB0);
        out_ready = 1'b0;
        rd("pp_status", 12'hF00, 32'h0000_0012);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pp_d", out_data, (i < 3) ? 32'hC1 + i : 32'hB0);
            tick();
        end
        check("pp_end", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(12'hF01, 32'hD0 + i);
        rd("ovf2", 12'hF00, 32'h0000_0112);
        wr(12'hF00, 32'hFFFF_FFFF);
        rd("ovf2_clr", 12'hF00, 32'h0000_0012);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check("empty2", {31'd0, out_valid}, 32'd0);

        // 5: cycle wrap, scratch, undefined offsets
        wr(12'hF02, 32'hFFFF_FFFE);
        rd("wrap_a", 12'hF02, 32'hFFFF_FFFE);
        rd("wrap_b", 12'hF02, 32'hFFFF_FFFF);
        rd("wrap_c", 12'hF02, 32'h0000_0000);
        wr(12'hF03, 32'hDEAD_BEEF);
        rd("scratch", 12'hF03, 32'hDEAD_BEEF);
        rd("off10", 12'hF10, 32'h0);
        rd("off04", 12'hF04, 32'h0);
        rd("txdata_rd", 12'hF01, 32'h0);
        address = 12'hF10;
        data    = 32'h1234_5678;
        wren    = 1'b1;
        #1;
        check("off10_wren", {31'd0, mem_wren}, 32'd0);
        tick();
        wren = 1'b0;
        rd("scratch2", 12'hF03, 32'hDEAD_BEEF);
        rd("dmem_keep", 12'h010, 32'h0000_0123);

        // 6: asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) wr(12'hF01, 32'hE0 + i);
        rd("pre_rst", 12'hF00, 32'h0000_000C);
        address   = 12'hF03;
        tick();
        out_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_q", q, mem_q);
        tick();
        reset = 1'b1;
        ecnt  = 0;
        rd("post_status", 12'hF00, 32'h0000_0001);
        rd("post_scratch", 12'hF03, 32'h0);
        rd("post_cycle", 12'hF02, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
